// File: rtl/cfg_pkg.sv
// Shared types and column sizing for the configuration chain loader.
// The default chain length is the per-tile chain summed over one column.
package cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    SET   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Per-tile chain order: slice -> cb_north -> sb -> cb_east
  localparam int SLICE_CHAIN_LEN    = 32;
  localparam int CB_NORTH_CHAIN_LEN = 16;
  localparam int SB_CHAIN_LEN       = 48;
  localparam int CB_EAST_CHAIN_LEN  = 32;
  localparam int TILES_PER_COLUMN   = 8;

  localparam int TILE_CHAIN_LEN = SLICE_CHAIN_LEN + CB_NORTH_CHAIN_LEN +
                                  SB_CHAIN_LEN + CB_EAST_CHAIN_LEN;
  localparam int DEFAULT_CHAIN_LEN = TILES_PER_COLUMN * TILE_CHAIN_LEN;

endpackage

// File: rtl/cfg_word_serializer.sv
// Holds one host word and walks a bit index across it, LSB first.
// o_last_bit flags the final bit of the held word.
module cfg_word_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_advance,
  input  logic [WORD_W-1:0] i_data,
  output logic              o_bit,
  output logic              o_last_bit
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] r_word;
  logic [IDX_W-1:0]  r_word_idx;

  // The index parks on the last bit so it never points past the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word     <= '0;
      r_word_idx <= '0;
    end else if (i_load) begin
      r_word     <= i_data;
      r_word_idx <= '0;
    end else if (i_advance && !o_last_bit) begin
      r_word_idx <= r_word_idx + IDX_W'(1);
    end
  end

  assign o_bit      = r_word[r_word_idx];
  assign o_last_bit = (r_word_idx == LAST_IDX);

endmodule

// File: rtl/cfg_chain_loader.sv
// Column configuration loader: accepts host words, shifts them bit-serially
// onto the tile chain with cen gated, then pulses set once the chain is full.
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN  = DEFAULT_CHAIN_LEN,
  parameter int WORD_W     = 32,
  parameter int SET_CYCLES = 1,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              chain_shift,
  output logic              chain_cen,
  output logic              chain_set,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic [2:0]        dbg_state
);

  localparam int SET_W = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_bit_count;
  logic [SET_W-1:0] r_set_cnt;
  logic             w_count_clr;
  logic             w_shift;
  logic             w_bit;
  logic             w_word_last;
  logic             w_last_chain;
  logic             w_set_last;
  logic             w_ready_base;
  logic             w_accept;

  cfg_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_advance  (w_shift),
    .i_data     (cfg_data),
    .o_bit      (w_bit),
    .o_last_bit (w_word_last)
  );

  assign w_shift      = (r_state == SHIFT);
  assign w_last_chain = (r_bit_count == CNT_W'(CHAIN_LEN - 1));
  assign w_set_last   = (r_set_cnt == SET_W'(SET_CYCLES - 1));

  // Valid/ready: a word transfers on a rising edge where cfg_valid and
  // cfg_ready are both high. Ready comes from registered state, except that
  // abort masks it so an aborting cycle never consumes a word.
  assign w_ready_base = (r_state == LOAD) ||
                        (w_shift && w_word_last && !w_last_chain);
  assign cfg_ready    = w_ready_base && !abort;
  assign w_accept     = cfg_valid && cfg_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_count_clr = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start && !abort) begin
          w_state_nxt = LOAD;
          w_count_clr = 1'b1;
        end
      end
      LOAD: begin
        if (abort)         w_state_nxt = IDLE;
        else if (w_accept) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (abort)                        w_state_nxt = IDLE;
        else if (w_last_chain)            w_state_nxt = SET;
        else if (w_word_last && !w_accept) w_state_nxt = LOAD;
      end
      SET: begin
        if (abort)           w_state_nxt = IDLE;
        else if (w_set_last) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bit_count <= '0;
      r_set_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_count_clr)  r_bit_count <= '0;
      else if (w_shift) r_bit_count <= r_bit_count + CNT_W'(1);
      if (r_state == SET && !w_set_last) r_set_cnt <= r_set_cnt + SET_W'(1);
      else                                r_set_cnt <= '0;
    end
  end

  assign chain_cen   = w_shift;
  assign chain_shift = w_shift && w_bit;
  assign chain_set   = (r_state == SET);
  assign busy        = (r_state == LOAD) || w_shift || (r_state == SET);
  assign done        = (r_state == DONE);
  assign bit_count   = r_bit_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: a 10-bit/4-bit-word instance for the main load
// scenarios and an 8-bit instance with a 3-cycle set pulse.
module tb_cfg_chain_loader;
  import cfg_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance A: CHAIN_LEN=10, WORD_W=4 ----------------
  logic       a_start, a_abort, a_cfg_valid;
  logic [3:0] a_cfg_data;
  logic       a_cfg_ready, a_chain_shift, a_chain_cen, a_chain_set, a_busy, a_done;
  logic [3:0] a_bit_count;
  logic [2:0] a_state;

  cfg_chain_loader #(.CHAIN_LEN(10), .WORD_W(4), .SET_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .cfg_valid(a_cfg_valid), .cfg_data(a_cfg_data), .cfg_ready(a_cfg_ready),
    .chain_shift(a_chain_shift), .chain_cen(a_chain_cen), .chain_set(a_chain_set),
    .busy(a_busy), .done(a_done), .bit_count(a_bit_count), .dbg_state(a_state)
  );

  // ---------------- instance B: CHAIN_LEN=8, WORD_W=4, SET_CYCLES=3 ----------------
  logic       b_start, b_abort, b_cfg_valid;
  logic [3:0] b_cfg_data;
  logic       b_cfg_ready, b_chain_shift, b_chain_cen, b_chain_set, b_busy, b_done;
  logic [3:0] b_bit_count;
  logic [2:0] b_state;

  cfg_chain_loader #(.CHAIN_LEN(8), .WORD_W(4), .SET_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .cfg_valid(b_cfg_valid), .cfg_data(b_cfg_data), .cfg_ready(b_cfg_ready),
    .chain_shift(b_chain_shift), .chain_cen(b_chain_cen), .chain_set(b_chain_set),
    .busy(b_busy), .done(b_done), .bit_count(b_bit_count), .dbg_state(b_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- scoreboard for instance A ----------------
  logic [0:0] exp_q[$];
  logic [0:0] exp_bit;
  bit  mon_en_a = 1'b0;
  int  a_shift_cnt = 0, a_gap_cnt = 0, a_set_cnt = 0;
  bit  a_seen_cen = 1'b0, a_prev_cen = 1'b0, a_prev_set = 1'b0, a_set_follow = 1'b0;

  always @(negedge clk) begin
    if (mon_en_a) begin
      if (a_chain_cen) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL a_extra_bit: got shift=%0b with no expected bit left", a_chain_shift);
        end else begin
          exp_bit = exp_q.pop_front();
          if (a_chain_shift !== exp_bit[0])
            $display("FAIL a_shift_bit: got %0b expected %0b (bit %0d)", a_chain_shift, exp_bit[0], a_bit_count);
          else n_pass++;
        end
        a_shift_cnt++;
        a_seen_cen = 1'b1;
      end else if (a_chain_set) begin
        a_set_cnt++;
        if (!a_prev_set) a_set_follow = a_prev_cen;
        a_seen_cen = 1'b0;
      end else if (!a_busy) begin
        a_seen_cen = 1'b0;
      end else if (a_seen_cen) begin
        a_gap_cnt++;
      end
      a_prev_cen = a_chain_cen;
      a_prev_set = a_chain_set;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_bits_a(input logic [3:0] w0, w1, w2, input int nbits);
    logic [3:0] words [3];
    logic [3:0] tmp;
    words[0] = w0; words[1] = w1; words[2] = w2;
    for (int i = 0; i < nbits; i++) begin
      tmp = words[i / 4];
      exp_q.push_back(tmp[i % 4]);
    end
  endtask

  task automatic drive_a(input logic [3:0] w0, w1, w2, input int gap_before, gap_len,
                         input int abort_at, start_at, input bit do_start,
                         output int accepted, output bit timed_out);
    logic [3:0] words [3];
    int idx, gap, shifts, cyc;
    bit aborted;
    words[0] = w0; words[1] = w1; words[2] = w2;
    idx = 0; gap = 0; shifts = 0; cyc = 0; aborted = 1'b0; accepted = 0;
    if (do_start) begin
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
    end
    while (cyc < 200) begin
      if (a_done || aborted) break;
      if (a_chain_cen) shifts++;
      a_abort     = (abort_at != 0) && a_chain_cen && (shifts == abort_at);
      a_start     = (start_at != 0) && a_chain_cen && (shifts == start_at);
      a_cfg_valid = (idx < 3) && !(idx == gap_before && gap < gap_len);
      a_cfg_data  = (idx < 3) ? words[idx] : 4'h0;
      #1;
      if (a_cfg_ready && !a_cfg_valid && idx == gap_before && gap < gap_len) gap++;
      if (a_cfg_valid && a_cfg_ready) begin accepted++; idx++; end
      if (a_abort) aborted = 1'b1;
      @(negedge clk);
      cyc++;
    end
    a_abort = 1'b0; a_start = 1'b0; a_cfg_valid = 1'b0; a_cfg_data = 4'h0;
    timed_out = (cyc >= 200);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    n_checks++;
    if ({a_cfg_ready, a_chain_shift, a_chain_cen, a_chain_set, a_busy, a_done, a_bit_count, a_state} !== 13'd0)
      $display("FAIL reset_a_outputs: got %0h expected 0",
               {a_cfg_ready, a_chain_shift, a_chain_cen, a_chain_set, a_busy, a_done, a_bit_count, a_state});
    else n_pass++;
    n_checks++;
    if ({b_cfg_ready, b_chain_shift, b_chain_cen, b_chain_set, b_busy, b_done, b_bit_count, b_state} !== 13'd0)
      $display("FAIL reset_b_outputs: got %0h expected 0",
               {b_cfg_ready, b_chain_shift, b_chain_cen, b_chain_set, b_busy, b_done, b_bit_count, b_state});
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_cfg_ready !== 1'b0 || a_state !== IDLE)
      $display("FAIL idle_after_reset: got ready=%0b state=%0d expected ready=0 state=0", a_cfg_ready, a_state);
    else n_pass++;
  endtask

  task automatic test_basic_load();
    int acc, s0, g0, t0;
    bit to;
    s0 = a_shift_cnt; g0 = a_gap_cnt; t0 = a_set_cnt;
    push_bits_a(4'h5, 4'hA, 4'h3, 10);
    drive_a(4'h5, 4'hA, 4'h3, -1, 0, 0, 0, 1'b1, acc, to);
    n_checks++; if (to) $display("FAIL basic_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (acc != 3) $display("FAIL basic_words: got %0d expected 3", acc); else n_pass++;
    n_checks++; if (a_shift_cnt - s0 != 10) $display("FAIL basic_cen_cycles: got %0d expected 10", a_shift_cnt - s0); else n_pass++;
    n_checks++; if (a_gap_cnt - g0 != 0) $display("FAIL basic_contiguous: got gap %0d expected 0", a_gap_cnt - g0); else n_pass++;
    n_checks++; if (a_set_cnt - t0 != 1) $display("FAIL basic_set_len: got %0d expected 1", a_set_cnt - t0); else n_pass++;
    n_checks++; if (a_set_follow !== 1'b1) $display("FAIL basic_set_follow: got %0b expected 1", a_set_follow); else n_pass++;
    n_checks++; if (a_done !== 1'b1 || a_bit_count !== 4'd10)
      $display("FAIL basic_done: got done=%0b count=%0d expected done=1 count=10", a_done, a_bit_count); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL basic_queue: got %0d left expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_valid_gap();
    int acc, s0, g0;
    bit to;
    s0 = a_shift_cnt; g0 = a_gap_cnt;
    push_bits_a(4'h5, 4'hA, 4'h3, 10);
    drive_a(4'h5, 4'hA, 4'h3, 1, 3, 0, 0, 1'b1, acc, to);
    n_checks++; if (to) $display("FAIL gap_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (a_gap_cnt - g0 != 3) $display("FAIL gap_cen_low: got %0d expected 3", a_gap_cnt - g0); else n_pass++;
    n_checks++; if (a_shift_cnt - s0 != 10) $display("FAIL gap_bits: got %0d expected 10", a_shift_cnt - s0); else n_pass++;
    n_checks++; if (a_bit_count !== 4'd10 || exp_q.size() != 0)
      $display("FAIL gap_count: got count=%0d left=%0d expected 10/0", a_bit_count, exp_q.size()); else n_pass++;
  endtask

  task automatic test_abort();
    int acc, t0;
    bit to;
    t0 = a_set_cnt;
    push_bits_a(4'h5, 4'hA, 4'h3, 6);
    drive_a(4'h5, 4'hA, 4'h3, -1, 0, 6, 0, 1'b1, acc, to);
    n_checks++; if (to) $display("FAIL abort_timeout: got timeout expected idle"); else n_pass++;
    n_checks++; if (a_state !== IDLE || a_chain_cen !== 1'b0 || a_busy !== 1'b0)
      $display("FAIL abort_idle: got state=%0d cen=%0b busy=%0b expected 0/0/0", a_state, a_chain_cen, a_busy); else n_pass++;
    n_checks++; if (a_bit_count !== 4'd6) $display("FAIL abort_count: got %0d expected 6", a_bit_count); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (a_set_cnt != t0 || exp_q.size() != 0)
      $display("FAIL abort_no_set: got sets=%0d left=%0d expected 0/0", a_set_cnt - t0, exp_q.size()); else n_pass++;
    push_bits_a(4'h6, 4'h9, 4'h1, 10);
    drive_a(4'h6, 4'h9, 4'h1, -1, 0, 0, 0, 1'b1, acc, to);
    n_checks++; if (to || a_done !== 1'b1 || a_bit_count !== 4'd10)
      $display("FAIL abort_reload: got done=%0b count=%0d expected 1/10", a_done, a_bit_count); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int acc, t0;
    bit to;
    t0 = a_set_cnt;
    push_bits_a(4'h5, 4'hA, 4'h3, 10);
    drive_a(4'h5, 4'hA, 4'h3, -1, 0, 0, 3, 1'b1, acc, to);
    n_checks++; if (to || acc != 3 || a_set_cnt - t0 != 1)
      $display("FAIL start_busy: got words=%0d sets=%0d expected 3/1", acc, a_set_cnt - t0); else n_pass++;
    n_checks++; if (a_bit_count !== 4'd10 || exp_q.size() != 0)
      $display("FAIL start_busy_count: got %0d left=%0d expected 10/0", a_bit_count, exp_q.size()); else n_pass++;
  endtask

  task automatic test_restart_from_done();
    logic [3:0] w0, w1, w2;
    int acc;
    bit to;
    w0 = 4'($urandom_range(0, 15)); w1 = 4'($urandom_range(0, 15)); w2 = 4'($urandom_range(0, 15));
    n_checks++; if (a_done !== 1'b1) $display("FAIL restart_pre_done: got %0b expected 1", a_done); else n_pass++;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    n_checks++; if (a_bit_count !== 4'd0 || a_state !== LOAD || a_cfg_ready !== 1'b1)
      $display("FAIL restart_clear: got count=%0d state=%0d ready=%0b expected 0/1/1", a_bit_count, a_state, a_cfg_ready);
    else n_pass++;
    push_bits_a(w0, w1, w2, 10);
    drive_a(w0, w1, w2, -1, 0, 0, 0, 1'b0, acc, to);
    n_checks++; if (to || a_bit_count !== 4'd10 || exp_q.size() != 0)
      $display("FAIL restart_load: got count=%0d left=%0d expected 10/0", a_bit_count, exp_q.size()); else n_pass++;
  endtask

  task automatic test_set_cycles_b();
    logic [3:0] bw [3];
    logic [7:0] exp_bits;
    int idx, shifts, sets, done_cyc, acc, cyc;
    bw[0] = 4'h9; bw[1] = 4'h6; bw[2] = 4'hF;
    exp_bits = {bw[1], bw[0]};
    idx = 0; shifts = 0; sets = 0; done_cyc = 0; acc = 0; cyc = 0;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    while (cyc < 60) begin
      if (b_chain_cen) begin
        n_checks++;
        if (shifts >= 8) $display("FAIL b_extra_bit: got shift %0d expected at most 8", shifts + 1);
        else if (b_chain_shift !== exp_bits[shifts])
          $display("FAIL b_shift_bit: got %0b expected %0b (bit %0d)", b_chain_shift, exp_bits[shifts], shifts);
        else n_pass++;
        shifts++;
      end
      if (b_chain_set) sets++;
      if (b_done) done_cyc++;
      if (done_cyc >= 4) break;
      b_cfg_valid = 1'b1;
      b_cfg_data  = bw[idx];
      #1;
      if (b_cfg_valid && b_cfg_ready) begin acc++; if (idx < 2) idx++; end
      @(negedge clk);
      cyc++;
    end
    b_cfg_valid = 1'b0;
    n_checks++; if (cyc >= 60) $display("FAIL b_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (acc != 2) $display("FAIL b_words: got %0d expected 2", acc); else n_pass++;
    n_checks++; if (sets != 3) $display("FAIL b_set_len: got %0d expected 3", sets); else n_pass++;
    n_checks++; if (shifts != 8 || b_bit_count !== 4'd8)
      $display("FAIL b_count: got shifts=%0d count=%0d expected 8/8", shifts, b_bit_count); else n_pass++;
  endtask

  task automatic test_async_reset();
    int cyc;
    mon_en_a = 1'b0;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0; a_cfg_valid = 1'b1; a_cfg_data = 4'h5;
    cyc = 0;
    while (!a_chain_cen && cyc < 20) begin @(negedge clk); cyc++; end
    n_checks++; if (!a_chain_cen) $display("FAIL arst_reach_shift: got cen=0 expected 1"); else n_pass++;
    a_cfg_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({a_cfg_ready, a_chain_shift, a_chain_cen, a_chain_set, a_busy, a_done, a_bit_count, a_state} !== 13'd0)
      $display("FAIL arst_outputs: got %0h expected 0",
               {a_cfg_ready, a_chain_shift, a_chain_cen, a_chain_set, a_busy, a_done, a_bit_count, a_state});
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (a_state !== IDLE || a_cfg_ready !== 1'b0)
        $display("FAIL arst_idle: got state=%0d ready=%0b expected 0/0", a_state, a_cfg_ready);
      else n_pass++;
    end
    a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    n_checks++; if (a_cfg_ready !== 1'b1) $display("FAIL arst_restart: got ready=%0b expected 1", a_cfg_ready); else n_pass++;
  endtask

  initial begin
    a_start = 1'b0; a_abort = 1'b0; a_cfg_valid = 1'b0; a_cfg_data = 4'h0;
    b_start = 1'b0; b_abort = 1'b0; b_cfg_valid = 1'b0; b_cfg_data = 4'h0;
    #1 rst = 1'b0;
    test_reset();
    mon_en_a = 1'b1;
    test_basic_load();
    test_valid_gap();
    test_abort();
    test_start_ignored();
    test_restart_from_done();
    test_set_cycles_b();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
